sync_tx: RTL and testbench
==========================

SYNC_TX -- requirements
Module: sync_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width in bits (legal range 1..16).
REQ-002 SHALL have parameter PREAMBLE, default 4'b1101, 4-bit sync pattern sent MSB-first before every payload.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-low (0 = reset, sampled on Clock rising edge).
REQ-005 SHALL have port start  input  1  frame request; accepted only when sampled high together with ready high.
REQ-006 SHALL have port data  input  DATA_W  payload word; captured in the accepting cycle.
REQ-007 SHALL have port ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have port w  output  1  serial bit stream (feeds the 1101 sequence detector input).
REQ-009 SHALL have port done  output  1  single-cycle pulse marking frame completion.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, PRE, DATA, GAP; all outputs registered, no combinational path from any input to any output.
REQ-011 IDLE: ready=1, w=0, done=0; on accept (start=1 at edge k), load data into shift register, preamble count=3, go PRE.
REQ-012 PRE: w drives PREAMBLE[3], [2], [1], [0] on the 4 cycles following edge k; ready=0; then DATA.
REQ-013 DATA: w drives data[DATA_W-1] down to data[0], one bit per cycle, MSB first; ready=0; after the last bit go GAP.
REQ-014 GAP: exactly 1 cycle with w=0, done=1, ready=0; then IDLE with ready=1.
REQ-015 Frame length SHALL be 4+DATA_W+1 cycles from accept edge to ready reasserting (13 cycles at DATA_W=8).
REQ-016 start while ready=0 SHALL be ignored; it is not queued. data changes after accept SHALL have no effect on the frame in flight.
REQ-017 start held high continuously SHALL produce back-to-back frames, each separated by the GAP cycle plus one IDLE cycle (w=0 for 2 cycles).
REQ-018 Bit counter SHALL be sized ceil(log2(DATA_W)), count down, and never wrap; reaching 0 terminates the state.
REQ-019 done SHALL never be high for more than one consecutive cycle.

Reset
REQ-020 Reset=0 at any edge, including mid-frame, SHALL force next-cycle state IDLE, w=0, ready=1, done=0, shift register and counters 0; the aborted frame is not resumed.
REQ-021 Reset=0 SHALL dominate start in the same cycle; start is not accepted.
REQ-022 First accept after reset release SHALL be possible at the first edge with Reset=1.

Structure
REQ-023 State encodings (IDLE=2'b00, PRE=2'b01, DATA=2'b10, GAP=2'b11) and the default PREAMBLE constant SHALL live in the shared package seq_pkg, reused by the detector bench.
REQ-024 The shift register SHALL be one sub-module piso_shreg (parallel load, shift-left, MSB out, synchronous active-low clear); the FSM and counters stay in sync_tx.

Verification
REQ-025 Reset held low 3 cycles, then released -> ready=1, w=0, done=0 throughout and after.
REQ-026 DATA_W=8, data=8'hA5, start pulse 1 cycle -> w = 1,1,0,1,1,0,1,0,0,1,0,1,0 then 0; done high only on cycle 13; ready back on cycle 14.
REQ-027 Same frame with start re-pulsed at cycles 3 and 8 and data changed to 8'hFF -> stream identical to REQ-026.
REQ-028 Reset driven low at cycle 6 of a data=8'h3C frame -> w=0, ready=1 next cycle, no done pulse; new start after release sends a full fresh frame.
REQ-029 start held high, data=8'h00, 3 frames -> each frame 1101 followed by eight 0s, done pulses exactly 14 cycles apart.
REQ-030 sync_tx w connected to the 1101 detector, data=8'h00 -> detector z=1 exactly once per frame, on the preamble's last bit cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sync transmitter and the 1101 sequence detector bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  // Transmitter FSM states; encodings are shared with the detector bench
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PRE  = 2'b01,
    DATA = 2'b10,
    GAP  = 2'b11
  } seq_state_t;

  // Sync pattern sent MSB-first ahead of every payload
  localparam logic [3:0] SEQ_PREAMBLE = 4'b1101;

  // Width of a down-counter that must reach n-1; never below one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in serial-out shift register: loads a word, shifts left, presents the MSB.
// Latency: load/shift take effect on the next rising edge; msb is a direct flop output.
// Backpressure: none; clear has priority over load, load over shift.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Clear, parallel load or shift-left by one position
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/sync_tx.sv
// Serial frame transmitter: 4-bit preamble, DATA_W payload bits MSB-first, one gap cycle.
// Latency: first preamble bit appears the cycle after accept; 4+DATA_W+1 cycles until ready again.
// Backpressure: start is honoured only while ready is high; requests while busy are dropped.
module sync_tx
  import seq_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter logic [3:0] PREAMBLE = SEQ_PREAMBLE
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              w,
  output logic              done
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [1:0]       pre_cnt;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             sr_msb;

  // ready is exactly "state is IDLE", so this is start qualified by ready
  assign accept = (state == IDLE) && start;

  // State register; reset forces IDLE and wins over any pending start
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Preamble and payload bit counters: count down, hold at zero, never wrap
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pre_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      if (accept) begin
        pre_cnt <= 2'd3;
      end else if (state == PRE && pre_cnt != 2'd0) begin
        pre_cnt <= pre_cnt - 2'd1;
      end

      if (state == PRE && pre_cnt == 2'd0) begin
        bit_cnt <= BIT_LAST;
      end else if (state == DATA && bit_cnt != '0) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  // Next-state logic: each busy state ends when its counter has reached zero
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = PRE;
      PRE:  if (pre_cnt == 2'd0) state_nxt = DATA;
      DATA: if (bit_cnt == '0) state_nxt = GAP;
      GAP:  state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded purely from flops; no input reaches an output combinationally
  always_comb begin
    ready = 1'b0;
    w     = 1'b0;
    done  = 1'b0;
    case (state)
      IDLE: ready = 1'b1;
      PRE:  w     = PREAMBLE[pre_cnt];
      DATA: w     = sr_msb;
      GAP:  done  = 1'b1;
    endcase
  end

  // Payload is latched at accept, so later changes on data cannot disturb the frame
  piso_shreg #(
    .W(DATA_W)
  ) u_shreg (
    .clk   (Clock),
    .clr_n (Reset),
    .load  (accept),
    .shift (state == DATA),
    .din   (data),
    .msb   (sr_msb)
  );

endmodule

// File: tb/tb_sync_tx.sv
// Bench for sync_tx: directed frames plus random traffic against a queue-based frame model.
// Latency: one observation per clock, sampled 1 time unit after the rising edge.
// Backpressure: model drops start while a frame is outstanding, as the DUT must.
module tb_sync_tx;

  localparam int DW = 8;

  typedef struct packed {
    logic w;
    logic ready;
    logic done;
  } exp_t;

  localparam exp_t IDLE_E = 3'b010;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] data  = '0;
  logic          ready;
  logic          w;
  logic          done;

  // Model: per-cycle expected outputs of the frame in flight; empty means idle
  exp_t q[$];
  int   n_checks  = 0;
  int   n_pass    = 0;
  int   cyc       = 0;
  int   acc_cyc   = -100;
  logic done_prev = 1'b0;
  logic [3:0] hist = '0;
  logic det_on    = 1'b0;
  int   done_times[$];
  logic [12:0] got;
  int   ndone_before;

  sync_tx #(.DATA_W(DW)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .start (start),
    .data  (data),
    .ready (ready),
    .w     (w),
    .done  (done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, cyc, obs, exp);
  endtask

  task automatic push_frame(input logic [DW-1:0] d);
    logic [3:0] p;
    p = 4'b1101;
    for (int i = 3; i >= 0; i--) q.push_back({p[i], 1'b0, 1'b0});
    for (int i = DW - 1; i >= 0; i--) q.push_back({d[i], 1'b0, 1'b0});
    q.push_back(3'b001);
  endtask

  // Drive inputs for one cycle, advance the model at the edge, then check the next cycle
  task automatic step(input logic s, input logic [DW-1:0] d, input logic r);
    exp_t e;
    logic was_idle;
    logic z;
    start = s;
    data  = d;
    Reset = r;
    @(posedge Clock);
    cyc++;
    if (!r) begin
      q.delete();
    end else begin
      was_idle = (q.size() == 0);
      if (!was_idle) q.delete(0);
      if (was_idle && s) begin
        push_frame(d);
        acc_cyc = cyc;
      end
    end
    #1;
    e = (q.size() != 0) ? q[0] : IDLE_E;
    check("w", 16'(w), 16'(e.w));
    check("ready", 16'(ready), 16'(e.ready));
    check("done", 16'(done), 16'(e.done));
    check("done_single", 16'(done_prev & done), 16'd0);
    done_prev = done;
    if (done === 1'b1) done_times.push_back(cyc);
    hist = {hist[2:0], w};
    if (det_on) begin
      z = (hist == 4'b1101);
      check("det_z", 16'(z), 16'((cyc - acc_cyc) == 3));
    end
  endtask

  initial begin
    // Reset held low 3 cycles with start asserted: must stay idle
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC3, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1);

    // Single A5 frame
    step(1'b1, 8'hA5, 1'b1);
    got = {12'd0, w};
    for (int c = 2; c <= 14; c++) begin
      step(1'b0, 8'h5A, 1'b1);
      if (c <= 13) got = {got[11:0], w};
    end
    check("a5_stream", 16'(got), 16'(13'b1101_10100101_0));
    check("a5_ready_back", 16'(ready), 16'd1);
    step(1'b0, 8'h00, 1'b1);

    // Same frame with start re-pulsed mid-frame and data changed to FF
    step(1'b1, 8'hA5, 1'b1);
    got = {12'd0, w};
    for (int c = 2; c <= 14; c++) begin
      step((c == 4 || c == 9), 8'hFF, 1'b1);
      if (c <= 13) got = {got[11:0], w};
    end
    check("repulse_stream", 16'(got), 16'(13'b1101_10100101_0));
    step(1'b0, 8'h00, 1'b1);

    // 3C frame aborted by reset during cycle 6 (start high too), then a fresh frame
    ndone_before = done_times.size();
    step(1'b1, 8'h3C, 1'b1);
    for (int c = 2; c <= 6; c++) step(1'b0, 8'h3C, 1'b1);
    step(1'b1, 8'h3C, 1'b0);
    check("abort_w", 16'(w), 16'd0);
    check("abort_ready", 16'(ready), 16'd1);
    step(1'b1, 8'h96, 1'b1);
    got = {12'd0, w};
    for (int c = 2; c <= 14; c++) begin
      step(1'b0, 8'h00, 1'b1);
      if (c <= 13) got = {got[11:0], w};
    end
    check("abort_no_done", 16'(done_times.size() - ndone_before), 16'd1);
    check("fresh_stream", 16'(got), 16'(13'b1101_10010110_0));
    step(1'b0, 8'h00, 1'b1);

    // start held high, data 00, three back-to-back frames with detector
    ndone_before = done_times.size();
    det_on = 1'b1;
    for (int i = 0; i < 42; i++) step(1'b1, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    det_on = 1'b0;
    check("b2b_done_count", 16'(done_times.size() - ndone_before), 16'd3);
    if (done_times.size() - ndone_before == 3) begin
      check("b2b_gap1", 16'(done_times[ndone_before + 1] - done_times[ndone_before]), 16'd14);
      check("b2b_gap2", 16'(done_times[ndone_before + 2] - done_times[ndone_before + 1]), 16'd14);
    end

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 2) == 0), DW'($urandom), ($urandom_range(0, 39) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
